// File: rtl/spike_event_arbiter.sv
// Spike event arbiter: timestamps per-neuron spike strobes, serialises them
// round-robin into a first-word-fall-through event FIFO read with valid/ready.
module spike_event_arbiter #(
    parameter int NUM_NEURONS = 8,
    parameter int TIME_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int DROP_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_NEURONS-1:0]           spike_valid,
    input  logic [NUM_NEURONS-1:0]           spike_on_off,
    input  logic                             time_enable,
    output logic                             event_valid,
    input  logic                             event_ready,
    output logic [$clog2(NUM_NEURONS)-1:0]   event_addr,
    output logic                             event_on_off,
    output logic [TIME_WIDTH-1:0]            event_time,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             overflow,
    output logic [DROP_WIDTH-1:0]            drop_count
);

    localparam int ADDR_W = $clog2(NUM_NEURONS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int CNT_W  = $clog2(NUM_NEURONS + 1);

    logic [TIME_WIDTH-1:0]  timestamp;

    logic [NUM_NEURONS-1:0] pending;
    logic [NUM_NEURONS-1:0] pend_on_off;
    logic [TIME_WIDTH-1:0]  pend_time [NUM_NEURONS];

    logic [ADDR_W-1:0]      rr_ptr;
    logic [ADDR_W-1:0]      grant_idx;
    logic                   grant_valid;
    logic [NUM_NEURONS-1:0] grant_onehot;
    logic [NUM_NEURONS-1:0] drop_vec;
    logic [CNT_W-1:0]       drop_num;
    logic [DROP_WIDTH:0]    drop_sum;

    logic [ADDR_W-1:0]      fifo_addr    [FIFO_DEPTH];
    logic                   fifo_on_off  [FIFO_DEPTH];
    logic [TIME_WIDTH-1:0]  fifo_time    [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;

    // Neuron index reached by stepping k places past base, wrapping at NUM_NEURONS.
    function automatic logic [ADDR_W-1:0] rr_index(input logic [ADDR_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_NEURONS) begin
            sum = sum - NUM_NEURONS;
        end
        return ADDR_W'(sum);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            timestamp <= '0;
        end else if (time_enable) begin
            timestamp <= timestamp + 1'b1;
        end
    end

    assign fifo_full = (level == LVL_W'(FIFO_DEPTH));

    // Fullness is judged on the cycle-start level, so a same-cycle pop never frees a slot early.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (!fifo_full) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (!grant_valid && pending[rr_index(rr_ptr, k)]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_index(rr_ptr, k);
                end
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        drop_vec     = '0;
        drop_num     = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            grant_onehot[i] = grant_valid && (grant_idx == ADDR_W'(i));
            drop_vec[i]     = spike_valid[i] && pending[i] && !grant_onehot[i];
            drop_num        = drop_num + CNT_W'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_count} + (DROP_WIDTH + 1)'(drop_num);
    end

    // A spike on a neuron being granted this cycle refills its slot; otherwise a busy slot drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            pend_on_off <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pend_time[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (spike_valid[i] && !drop_vec[i]) begin
                    pending[i]     <= 1'b1;
                    pend_on_off[i] <= spike_on_off[i];
                    pend_time[i]   <= timestamp;
                end else if (grant_onehot[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_idx == ADDR_W'(NUM_NEURONS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (|drop_vec) begin
            overflow   <= 1'b1;
            drop_count <= drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
        end
    end

    assign push = grant_valid;
    assign pop  = event_valid && event_ready;

    // Storage is left unreset; the head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]   <= grant_idx;
            fifo_on_off[wr_ptr] <= pend_on_off[grant_idx];
            fifo_time[wr_ptr]   <= pend_time[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    assign event_valid  = (level != '0);
    assign event_addr   = event_valid ? fifo_addr[rd_ptr]   : '0;
    assign event_on_off = event_valid ? fifo_on_off[rd_ptr] : 1'b0;
    assign event_time   = event_valid ? fifo_time[rd_ptr]   : '0;
    assign fifo_level   = level;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Scoreboard bench for spike_event_arbiter: expected events are queued when
// spikes are driven and compared as the readout side accepts them.
module tb_spike_event_arbiter;

    localparam int N     = 8;
    localparam int TW    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int AW    = $clog2(N);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N-1:0]         spike_valid = '0;
    logic [N-1:0]         spike_on_off = '0;
    logic                 time_enable = 1'b1;
    logic                 event_ready = 1'b0;
    logic                 event_valid;
    logic [AW-1:0]        event_addr;
    logic                 event_on_off;
    logic [TW-1:0]        event_time;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                 overflow;
    logic [DW-1:0]        drop_count;

    typedef struct {
        int addr;
        int on_off;
        int tm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   tb_ts    = 0;
    int   tb_rr    = 0;

    spike_event_arbiter #(
        .NUM_NEURONS(N),
        .TIME_WIDTH (TW),
        .FIFO_DEPTH (DEPTH),
        .DROP_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spike_valid (spike_valid),
        .spike_on_off(spike_on_off),
        .time_enable (time_enable),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_addr  (event_addr),
        .event_on_off(event_on_off),
        .event_time  (event_time),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp: wraps at 2^TW, holds while time_enable is low.
    always @(posedge clk) begin
        if (reset) begin
            tb_ts <= 0;
        end else if (time_enable) begin
            tb_ts <= (tb_ts + 1) % (1 << TW);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Accepted events are compared at the falling edge, away from the pop edge.
    always @(negedge clk) begin
        if (!reset && event_valid === 1'b1 && event_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_event", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("event_addr", 64'(event_addr), 64'(mon_e.addr));
                checkOutput("event_on_off", 64'(event_on_off), 64'(mon_e.on_off));
                checkOutput("event_time", 64'(event_time), 64'(mon_e.tm));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of spikes; when record is set, queues the events in round-robin order.
    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] on_off, input bit record);
        int last;
        bit any;
        last = 0;
        any  = 1'b0;
        spike_valid  = valid;
        spike_on_off = on_off;
        if (record) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (tb_rr + k) % N;
                if (valid[idx]) begin
                    exp_q.push_back('{idx, int'(on_off[idx]), tb_ts});
                    last = idx;
                    any  = 1'b1;
                end
            end
            if (any) begin
                tb_rr = (last + 1) % N;
            end
        end
        tick();
        spike_valid  = '0;
        spike_on_off = '0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        exp_q.delete();
        tb_rr = 0;
    endtask

    task automatic wait_ts(input int target);
        for (int c = 0; c < 40 && tb_ts != target; c++) begin
            tick();
        end
        if (tb_ts != target) begin
            checkOutput("ts_wait_timeout", 64'(tb_ts), 64'(target));
        end
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int c = 0; c < budget && !(exp_q.size() == 0 && fifo_level == 0); c++) begin
            tick();
        end
        checkOutput({tag, "_queue_empty"}, 64'(exp_q.size()), 0);
        checkOutput({tag, "_level"}, 64'(fifo_level), 0);
    endtask

    function automatic logic [N-1:0] one_hot(input int k);
        return N'(1) << (k % N);
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, %0d events outstanding", exp_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        do_reset(2);
        checkOutput("reset_valid", 64'(event_valid), 0);
        checkOutput("reset_level", 64'(fifo_level), 0);
        checkOutput("reset_overflow", 64'(overflow), 0);
        checkOutput("reset_drops", 64'(drop_count), 0);
        checkOutput("reset_addr", 64'(event_addr), 0);
        checkOutput("reset_on_off", 64'(event_on_off), 0);
        checkOutput("reset_time", 64'(event_time), 0);

        $display("[TB] single spike");
        wait_ts(5);
        applyStimulus(8'h08, 8'h08, 1'b1);
        checkOutput("latency_t1_valid", 64'(event_valid), 0);
        tick();
        checkOutput("latency_t2_valid", 64'(event_valid), 1);
        checkOutput("single_level", 64'(fifo_level), 1);
        checkOutput("single_addr", 64'(event_addr), 3);
        checkOutput("single_time", 64'(event_time), 5);
        repeat (3) tick();
        checkOutput("held_head_addr", 64'(event_addr), 3);
        checkOutput("held_head_on_off", 64'(event_on_off), 1);
        event_ready = 1'b1;
        wait_drain(10, "single");

        $display("[TB] simultaneous bursts");
        for (int b = 0; b < 2; b++) begin
            applyStimulus(8'hFF, 8'hA5, 1'b1);
            checkOutput("burst_t1_valid", 64'(event_valid), 0);
            for (int k = 0; k < N; k++) begin
                tick();
                checkOutput("burst_stream_valid", 64'(event_valid), 1);
            end
            tick();
            checkOutput("burst_end_valid", 64'(event_valid), 0);
        end
        wait_drain(5, "burst");

        $display("[TB] timestamp hold");
        time_enable = 1'b0;
        repeat (3) tick();
        applyStimulus(8'h40, 8'h00, 1'b1);
        time_enable = 1'b1;
        wait_drain(10, "hold");

        $display("[TB] backpressure");
        event_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(one_hot(k), (k % 3 == 0) ? one_hot(k) : '0, 1'b1);
        end
        checkOutput("bp_level_full", 64'(fifo_level), DEPTH);
        repeat (2) tick();
        checkOutput("bp_level_held", 64'(fifo_level), DEPTH);
        checkOutput("bp_no_drops", 64'(drop_count), 0);
        checkOutput("bp_no_overflow", 64'(overflow), 0);
        event_ready = 1'b1;
        wait_drain(60, "bp");

        $display("[TB] collision");
        event_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(one_hot(k), '0, 1'b1);
        end
        applyStimulus(8'h04, 8'h04, 1'b1);
        applyStimulus(8'h04, 8'h00, 1'b0);
        checkOutput("collision_overflow", 64'(overflow), 1);
        checkOutput("collision_drops", 64'(drop_count), 1);
        checkOutput("collision_level", 64'(fifo_level), DEPTH);
        event_ready = 1'b1;
        wait_drain(60, "collision");
        checkOutput("collision_drops_after", 64'(drop_count), 1);

        $display("[TB] timestamp wrap");
        wait_ts(15);
        applyStimulus(8'h02, 8'h02, 1'b1);
        applyStimulus(8'h02, 8'h00, 1'b1);
        tick();
        checkOutput("grant_refill_no_drop", 64'(drop_count), 1);
        wait_drain(10, "wrap");

        $display("[TB] reset mid-operation");
        event_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(one_hot(k), '0, 1'b1);
        end
        applyStimulus(8'hE0, 8'hE0, 1'b0);
        checkOutput("pre_reset_level", 64'(fifo_level), 5);
        do_reset(1);
        checkOutput("mid_reset_valid", 64'(event_valid), 0);
        checkOutput("mid_reset_level", 64'(fifo_level), 0);
        checkOutput("mid_reset_overflow", 64'(overflow), 0);
        checkOutput("mid_reset_drops", 64'(drop_count), 0);
        event_ready = 1'b1;
        repeat (20) tick();
        checkOutput("post_reset_valid", 64'(event_valid), 0);
        checkOutput("post_reset_level", 64'(fifo_level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_event_arbiter.md
Name: spike_event_arbiter

Overview:
Downstream of the neuron array. Collects the per-neuron spike_out strobes (valid, on_off) from NUM_NEURONS neurons and timestamps each one on arrival. It serialises them through round-robin arbitration into a first-word-fall-through event FIFO. The FIFO is read by the off-chip/readout interface with a valid/ready handshake.

Parameters:
NUM_NEURONS, 8, number of neuron spike inputs (≥2)
TIME_WIDTH, 16, timestamp counter width
FIFO_DEPTH, 16, event FIFO entries (power of 2, ≥2)
DROP_WIDTH, 8, width of saturating dropped-event counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
spike_valid  in  NUM_NEURONS  per-neuron spike strobe (neuron output_spike.valid)
spike_on_off  in  NUM_NEURONS  per-neuron spike type, 1=onset, 0=refractory end
time_enable  in  1  timestamp tick
event_valid  out  1  FIFO head valid
event_ready  in  1  consumer accepts head
event_addr  out  $clog2(NUM_NEURONS)  neuron index of head event
event_on_off  out  1  type of head event
event_time  out  TIME_WIDTH  timestamp of head event
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky, an event was dropped
drop_count  out  DROP_WIDTH  saturating dropped-event count

Behaviour:
- Reset: clk and reset as already decided (reset reset, synchronous, active-high; clock clk). All pending flags 0; timestamp 0; RR pointer 0; FIFO empty. Outputs after reset: event_valid=0, fifo_level=0, overflow=0, drop_count=0. event_addr/on_off/time=0. Reset mid-operation discards all pending and queued events.
- Timestamp: counter increments on each clk with time_enable=1 and wraps 2^TIME_WIDTH-1 -> 0.
- Capture: neuron i with spike_valid[i]=1 in cycle t is registered at the end of t. Stored: pending[i]=1, on_off[i]=spike_on_off[i], time[i]=current timestamp value in cycle t (pre-increment).
- Collision: spike on i while pending[i]=1 and i is not granted in that cycle. The new spike is dropped and the stored entry is kept. overflow is set and drop_count increments, saturating at all-ones.
- Same-cycle grant and new spike on i: the grant takes the old entry and the new spike becomes pending. No drop.
- Arbitration: in each cycle where any pending=1 and FIFO not full, grant exactly one neuron. The search starts at index rr_ptr, ascending with wrap. The granted entry {i, on_off[i], time[i]} is pushed and pending[i] is cleared. rr_ptr <= i+1 mod NUM_NEURONS.
- Full: no grant when fifo_level==FIFO_DEPTH at cycle start, even if a pop occurs in the same cycle. Pending entries wait; they are not dropped.
- FIFO: FWFT. event_valid = (level!=0). Head outputs are stable while event_valid && !event_ready. Pop when event_valid && event_ready. Simultaneous push and pop leaves level unchanged. Pop on empty is ignored.
- Latency: spike sampled in cycle t with FIFO empty and no competitors produces event_valid=1 in cycle t+2.
- Throughput: 1 event/cycle sustained.
- Drop events never alter the FIFO.

Test Plan:
- Single spike: reset, time_enable=1 constantly, spike_valid[3]=1/on_off=1 at timestamp 5 -> event_valid two cycles later with addr=3, on_off=1, time=5. Pop -> level 0.
- Simultaneous burst: all 8 spike_valid=1 in one cycle, event_ready=1 -> 8 events in consecutive cycles, addr 0..7, equal timestamps. Next burst starts from addr 0 again (ptr wrapped).
- Backpressure: event_ready=0, FIFO_DEPTH=16, 20 spikes staggered across neurons -> level saturates at 16, 4 pending held, no drops. Releasing ready delivers all 20 in order.
- Collision: event_ready=0, FIFO full, neuron 2 spikes twice while pending -> overflow=1, drop_count=1. First-captured timestamp delivered, second lost.
- Timestamp wrap: TIME_WIDTH=4, spike at counter 15 then at counter 0 -> event_time 15 then 0.
- Reset mid-operation: 5 events queued and 3 pending, assert reset one cycle -> event_valid=0, level=0, overflow=0, no stale events emitted afterwards.
